// File: rtl/deser_pkg.sv
// deser_pkg
// Shared definitions for the serial deserializer slice.
//   state_t     : deserializer FSM states (IDLE / DATA / PARITY)
//   FIFO_DEPTH  : number of completed words the output buffer can hold
package deser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/deser_out_buf.sv
// deser_out_buf
// Small circular FIFO that holds completed frames ({word, parity error})
// until the consumer takes them. A push that arrives while the buffer is
// full is dropped unless a pop happens in the same cycle; a drop raises a
// sticky overflow flag that only reset clears.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_pushValid  : a completed frame is offered this cycle
//   i_pushData   : word of the offered frame
//   i_pushPerr   : parity error flag of the offered frame
//   i_popReady   : consumer accepts the head entry when o_valid is high
//   o_data       : head entry word
//   o_perr       : head entry parity error flag
//   o_valid      : buffer is non-empty
//   o_overflow   : sticky, a frame has been dropped since reset
module deser_out_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pushValid,
    input  logic [DATA_W-1:0] i_pushData,
    input  logic              i_pushPerr,
    input  logic              i_popReady,
    output logic [DATA_W-1:0] o_data,
    output logic              o_perr,
    output logic              o_valid,
    output logic              o_overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_memData [DEPTH];
    logic              r_memPerr [DEPTH];
    logic [PTR_W-1:0]  r_rdPtr;
    logic [PTR_W-1:0]  r_wrPtr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              w_full;
    logic              w_pop;
    logic              w_accept;
    logic              w_drop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // A pop frees the slot being written when full, so push and pop in the
    // same cycle is always safe to accept.
    assign w_full     = (r_count == FULL_CNT);
    assign o_valid    = (r_count != '0);
    assign w_pop      = o_valid & i_popReady;
    assign w_accept   = i_pushValid & (~w_full | w_pop);
    assign w_drop     = i_pushValid & w_full & ~w_pop;
    assign o_data     = r_memData[r_rdPtr];
    assign o_perr     = r_memPerr[r_rdPtr];
    assign o_overflow = r_overflow;

    // Storage, pointers, occupancy and the sticky overflow flag. Storage is
    // cleared on reset so the head outputs read zero while empty after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_memData[i] <= '0;
                r_memPerr[i] <= 1'b0;
            end
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_memData[r_wrPtr] <= i_pushData;
                r_memPerr[r_wrPtr] <= i_pushPerr;
                r_wrPtr            <= nextPtr(r_wrPtr);
            end
            if (w_pop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_deser.sv
// serial_deser
// Serial-to-parallel deserializer. A '1' sampled in IDLE is the start bit,
// followed by DATA_W data bits (MSB first) and, optionally, an even parity
// bit. Completed frames are registered for one cycle and then pushed into a
// small output FIFO. Only cycles with din_en=1 carry bits; the deserializer
// never stalls the upstream source.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   din        : serial bit
//   din_en     : din is meaningful this cycle
//   out_data   : oldest assembled word
//   out_perr   : parity error flag for out_data
//   out_valid  : out_data/out_perr hold a valid word
//   out_ready  : consumer accepts the word when out_valid=1
//   overflow   : sticky, a completed frame was dropped
//   busy       : FSM is inside a frame
module serial_deser
    import deser_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              din_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_perr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_t            r_state;
    state_t            w_stateNext;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cntNext;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shiftNext;
    logic              w_frameDone;
    logic [DATA_W-1:0] w_frameData;
    logic              w_framePerr;
    logic              r_pushValid;
    logic [DATA_W-1:0] r_pushData;
    logic              r_pushPerr;

    // FSM, counter and shift register state. Everything returns to a clean
    // IDLE on reset so a partially received frame is simply lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_shift <= w_shiftNext;
        end
    end

    // Next-state and frame completion. Nothing moves unless din_en is high.
    // The counter saturates at DATA_W on the last data bit and is cleared
    // by the next start bit, so it never wraps. In the no-parity case the
    // completed word includes the bit being sampled this cycle.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_shiftNext = r_shift;
        w_frameDone = 1'b0;
        w_frameData = {r_shift[DATA_W-2:0], din};
        w_framePerr = 1'b0;
        if (din_en) begin
            case (r_state)
                IDLE: begin
                    if (din) begin
                        w_stateNext = DATA;
                        w_cntNext   = '0;
                    end
                end
                DATA: begin
                    w_shiftNext = {r_shift[DATA_W-2:0], din};
                    w_cntNext   = r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
                        if (PARITY_EN != 0) begin
                            w_stateNext = PARITY;
                        end else begin
                            w_stateNext = IDLE;
                            w_frameDone = 1'b1;
                        end
                    end
                end
                PARITY: begin
                    w_stateNext = IDLE;
                    w_frameDone = 1'b1;
                    w_frameData = r_shift;
                    w_framePerr = (^r_shift) ^ din;
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    // One-cycle staging register between frame completion and the FIFO
    // push, giving a fixed one-cycle latency from the last bit to out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pushValid <= 1'b0;
            r_pushData  <= '0;
            r_pushPerr  <= 1'b0;
        end else begin
            r_pushValid <= w_frameDone;
            if (w_frameDone) begin
                r_pushData <= w_frameData;
                r_pushPerr <= w_framePerr;
            end
        end
    end

    assign busy = (r_state != IDLE);

    deser_out_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_outBuf (
        .clk         (clk),
        .rst         (rst),
        .i_pushValid (r_pushValid),
        .i_pushData  (r_pushData),
        .i_pushPerr  (r_pushPerr),
        .i_popReady  (out_ready),
        .o_data      (out_data),
        .o_perr      (out_perr),
        .o_valid     (out_valid),
        .o_overflow  (overflow)
    );

endmodule

// File: tb/tb_serial_deser.sv
// tb_serial_deser
// Directed bench for serial_deser (DATA_W=8, PARITY_EN=1). Inputs change
// 1 time unit after each rising edge; outputs are checked at that point.
module tb_serial_deser;

    logic       clk;
    logic       rst;
    logic       din;
    logic       din_en;
    logic [7:0] out_data;
    logic       out_perr;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;
    logic       busy;

    int checks = 0;
    int errors = 0;

    serial_deser #(
        .DATA_W    (8),
        .PARITY_EN (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_en    (din_en),
        .out_data  (out_data),
        .out_perr  (out_perr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .busy      (busy)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one bit slot and move to just after the next rising edge.
    task automatic applyStimulus(input logic en, input logic bitVal);
        din_en = en;
        din    = bitVal;
        @(posedge clk);
        #1;
    endtask

    // Single comparison point.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
            $error("[TB] %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Start bit, 8 data bits MSB first, parity bit. With gaps, a din_en=0
    // slot carrying the inverted next bit precedes every bit after the start.
    task automatic sendFrame(input logic [7:0] data, input logic par, input bit gaps);
        applyStimulus(1'b1, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            if (gaps) applyStimulus(1'b0, ~data[i]);
            applyStimulus(1'b1, data[i]);
        end
        if (gaps) applyStimulus(1'b0, ~par);
        applyStimulus(1'b1, par);
    endtask

    // Directed sequence.
    initial begin
        rst       = 1'b1;
        din       = 1'b0;
        din_en    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0);

        // Reset values
        checkOutput("rst_valid", 16'(out_valid), 16'h0);
        checkOutput("rst_data", 16'(out_data), 16'h0);
        checkOutput("rst_perr", 16'(out_perr), 16'h0);
        checkOutput("rst_overflow", 16'(overflow), 16'h0);
        checkOutput("rst_busy", 16'(busy), 16'h0);

        // Mid-frame reset discards the partial frame
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("midframe_busy", 16'(busy), 16'h1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_busy", 16'(busy), 16'h0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("post_rst_valid", 16'(out_valid), 16'h0);
        checkOutput("post_rst_busy", 16'(busy), 16'h0);
        sendFrame(8'hC3, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("fresh_valid", 16'(out_valid), 16'h1);
        checkOutput("fresh_data", 16'(out_data), 16'h00C3);
        applyStimulus(1'b0, 1'b0);

        // Basic frame and one-cycle latency/pulse
        sendFrame(8'hA5, 1'b0, 1'b0);
        checkOutput("a5_latency_valid", 16'(out_valid), 16'h0);
        checkOutput("a5_busy_idle", 16'(busy), 16'h0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("a5_valid", 16'(out_valid), 16'h1);
        checkOutput("a5_data", 16'(out_data), 16'h00A5);
        checkOutput("a5_perr", 16'(out_perr), 16'h0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("a5_pulse_end", 16'(out_valid), 16'h0);

        // Parity error
        sendFrame(8'hA5, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("perr_valid", 16'(out_valid), 16'h1);
        checkOutput("perr_data", 16'(out_data), 16'h00A5);
        checkOutput("perr_flag", 16'(out_perr), 16'h1);
        applyStimulus(1'b0, 1'b0);

        // Gapped frame, gap slots carry misleading din values
        sendFrame(8'h3C, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("gap_valid", 16'(out_valid), 16'h1);
        checkOutput("gap_data", 16'(out_data), 16'h003C);
        checkOutput("gap_perr", 16'(out_perr), 16'h0);
        applyStimulus(1'b0, 1'b0);

        // Back-pressure and overflow
        out_ready = 1'b0;
        sendFrame(8'h11, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("bp_first_data", 16'(out_data), 16'h0011);
        sendFrame(8'h22, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("bp_full_no_ovf", 16'(overflow), 16'h0);
        checkOutput("bp_stable_data", 16'(out_data), 16'h0011);
        sendFrame(8'h33, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("ovf_set", 16'(overflow), 16'h1);
        checkOutput("ovf_head_kept", 16'(out_data), 16'h0011);
        out_ready = 1'b1;
        #1;
        checkOutput("drain_1", 16'(out_data), 16'h0011);
        applyStimulus(1'b0, 1'b0);
        checkOutput("drain_2_valid", 16'(out_valid), 16'h1);
        checkOutput("drain_2", 16'(out_data), 16'h0022);
        applyStimulus(1'b0, 1'b0);
        checkOutput("drain_empty", 16'(out_valid), 16'h0);
        checkOutput("ovf_sticky", 16'(overflow), 16'h1);

        // Reset clears the sticky flag
        rst = 1'b1;
        #2;
        checkOutput("ovf_cleared", 16'(overflow), 16'h0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0);

        // Full FIFO, push coinciding with a pop
        out_ready = 1'b0;
        sendFrame(8'h44, 1'b0, 1'b0);
        sendFrame(8'h55, 1'b0, 1'b0);
        sendFrame(8'h66, 1'b1, 1'b0);
        out_ready = 1'b1;
        #1;
        checkOutput("pp_head_44", 16'(out_data), 16'h0044);
        applyStimulus(1'b0, 1'b0);
        checkOutput("pp_no_ovf", 16'(overflow), 16'h0);
        checkOutput("pp_data_55", 16'(out_data), 16'h0055);
        applyStimulus(1'b0, 1'b0);
        checkOutput("pp_data_66", 16'(out_data), 16'h0066);
        checkOutput("pp_perr_66", 16'(out_perr), 16'h1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("pp_empty", 16'(out_valid), 16'h0);
        checkOutput("pp_no_ovf_end", 16'(overflow), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
